dcache_data_ctrl: RTL and testbench
===================================

# dcache_data_ctrl

Sequencer and port arbiter for the 4-way data-cache data RAM (`ddram`). It shares the single RAM port between CPU load/store word accesses and line-maintenance bursts: refill from memory and writeback of an evicted line. It sits between the dcache FSM, the `ddram` instance and the memory bus interface.

## Interface
- `DW`, 32, data word width; must match `ddram` `dw`
- `IW`, `` `D_INDEX_WIDTH ``, set index width
- `WO`, `` `D_WO_WIDTH ``, word-offset width; line = 2^WO words
---
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU word access request; held until `cpu_ack`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_index`  in  IW  set
- `cpu_way`  in  2  hit way
- `cpu_offset`  in  WO  word in line
- `cpu_wdata`  in  DW  store data
- `cpu_rdata`  out  DW  load data, valid with `cpu_ack`
- `cpu_ack`  out  1  one-cycle access completion pulse
- `fill_start`  in  1  start line refill (one-cycle pulse)
- `wb_start`  in  1  start line writeback (one-cycle pulse)
- `line_index`  in  IW  maintenance set; sampled at start
- `line_way`  in  2  maintenance way; sampled at start
- `busy`  out  1  maintenance in progress
- `done`  out  1  one-cycle pulse: maintenance sequence complete
- `mem_rdata`  in  DW  refill word
- `mem_rvalid`  in  1  refill word valid
- `mem_rready`  out  1  accepting refill word
- `mem_wdata`  out  DW  writeback word
- `mem_wvalid`  out  1  writeback word valid
- `mem_wready`  in  1  memory accepts writeback word
- `mem_wlast`  out  1  current writeback word is the last of the line
- `ram_index`, `ram_way`, `ram_offset`, `ram_din`, `ram_we`, `ram_en`  out  IW/2/WO/DW/1/1  `ddram` port drive
- `ram_dout0..3`  in  DW each  `ddram` combinational read data

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - `wb_start` → WB.
  - `fill_start` alone → FILL.
  - Both in the same cycle → WB, then FILL on the same latched index/way (evict-then-refill).
  - The latched-index/way start flag is stored so that FILL follows WB automatically.
- CPU access, served only in IDLE with no start pulse that cycle:
  - Drive `ram_en` = 1, `ram_we` = `cpu_we`, address from the `cpu_*` inputs, `ram_din` = `cpu_wdata`.
  - Register `cpu_rdata` = `ram_dout[cpu_way]` and `cpu_ack` = 1 on the next cycle.
  - Requests are not accepted in the ack cycle, so each request is served exactly once.
- A maintenance start pulse wins over `cpu_req` in the same cycle. The CPU waits: `cpu_ack` stays 0 until the controller returns to IDLE.
- WB:
  - Word counter `cnt` (WO bits) starts at 0.
  - `ram_en` = 1, `ram_we` = 0, `ram_offset` = `cnt`.
  - `mem_wvalid` = 1, `mem_wdata` = `ram_dout[line_way]`, `mem_wlast` = (`cnt` == 2^WO−1).
  - On `mem_wvalid & mem_wready`: `cnt`++.
  - At the last word: → FILL if a fill is pending, else → DONE, with `cnt` = 0.
- FILL:
  - `mem_rready` = 1, `ram_offset` = `cnt`, `ram_din` = `mem_rdata`.
  - `ram_en` = `ram_we` = `mem_rvalid`.
  - Each valid word is written at that posedge and `cnt`++.
  - The last word → DONE.
- DONE: `done` = 1 for one cycle → IDLE. `busy` = 1 in WB, FILL and DONE.
- `cnt` wraps from 2^WO−1 to 0; the sequence ends exactly on the wrap.
- Start pulses while `busy` are ignored; the requester must not issue them.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt` 0; pending flag 0.
- `rst_n` low mid-burst aborts immediately. RAM contents written so far are retained, and no `done` is produced.
- CPU load/store latency: accept cycle + 1 (`cpu_ack` in cycle N+1). The store is written at the accept posedge.
- WB: one word per cycle when `mem_wready` is held high, so 2^WO cycles plus 1 DONE cycle.
  - `mem_wvalid` and `mem_wdata` stay stable while `mem_wready` is low.
- FILL: one word per `mem_rvalid` cycle; no internal stalls.
- Start pulse to first RAM burst access: 1 cycle (the state registered at the pulse edge).

## Structure
- Shared package/header (`cache.h`): state encodings `DDC_IDLE`, `DDC_WB`, `DDC_FILL`, `DDC_DONE`; line word count `(1 << `D_WO_WIDTH)`.
- One natural sub-module: `ddc_way_mux`, a 4:1 DW-bit mux selecting `ram_dout0..3` by way. It is used by both the CPU read path and the WB path.

## Test plan
- CPU store then load: store `cpu_index`=5, way 2, offset 3, data 0xDEADBEEF. Expect `cpu_ack` one cycle later, then the load returns 0xDEADBEEF with `cpu_ack` one cycle after accept.
- Refill: `fill_start` on index 9 way 1; memory supplies words 0x100+i with `mem_rvalid` gaps every other cycle. Expect all 2^WO words in way 1 at offsets i, `done` pulse once, `busy` low after.
- Writeback with backpressure: preload a line; `wb_start`; toggle `mem_wready` randomly. Expect ordered words, `mem_wdata` stable while stalled, `mem_wlast` only on offset 2^WO−1.
- Combined: `wb_start` + `fill_start` same cycle. Expect a full WB, then FILL of the same set/way; the old data appears on mem, the new data is in RAM, one `done`.
- Contention: `cpu_req` asserted in the same cycle as `fill_start`. Expect no `cpu_ack` until after `done`, then the request is served with correct (refilled) data.
- Reset mid-FILL: drop `rst_n` after 2 words. Expect all outputs 0 and state IDLE; the first 2 words remain in RAM; no `done`.

Source files
------------

// File: rtl/dcache_data_ctrl_pkg.sv
// Shared definitions for the data-cache data RAM sequencer: geometry
// defaults and the controller state encoding.
package dcache_data_ctrl_pkg;

   // Default cache geometry: 64 sets, 8 words per line.
   localparam int D_INDEX_WIDTH = 6;
   localparam int D_WO_WIDTH    = 3;
   localparam int D_LINE_WORDS  = 1 << D_WO_WIDTH;

   typedef enum logic [1:0] {
      DDC_IDLE = 2'd0,
      DDC_WB   = 2'd1,
      DDC_FILL = 2'd2,
      DDC_DONE = 2'd3
   } ddc_state_e;

endpackage

// File: rtl/dcache_data_ctrl_if.sv
// Bundle of CPU, maintenance, memory-bus and ddram-port signals around the
// data RAM sequencer. slave = the controller, master = its surroundings.
interface dcache_data_ctrl_if #(
   parameter int DW = 32,
   parameter int IW = dcache_data_ctrl_pkg::D_INDEX_WIDTH,
   parameter int WO = dcache_data_ctrl_pkg::D_WO_WIDTH
) ();

   // CPU word access
   logic          cpu_req;
   logic          cpu_we;
   logic [IW-1:0] cpu_index;
   logic [1:0]    cpu_way;
   logic [WO-1:0] cpu_offset;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;

   // Line maintenance control
   logic          fill_start;
   logic          wb_start;
   logic [IW-1:0] line_index;
   logic [1:0]    line_way;
   logic          busy;
   logic          done;

   // Memory bus
   logic [DW-1:0] mem_rdata;
   logic          mem_rvalid;
   logic          mem_rready;
   logic [DW-1:0] mem_wdata;
   logic          mem_wvalid;
   logic          mem_wready;
   logic          mem_wlast;

   // ddram port
   logic [IW-1:0] ram_index;
   logic [1:0]    ram_way;
   logic [WO-1:0] ram_offset;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic          ram_en;
   logic [DW-1:0] ram_dout0;
   logic [DW-1:0] ram_dout1;
   logic [DW-1:0] ram_dout2;
   logic [DW-1:0] ram_dout3;

   modport slave (
      input  cpu_req, cpu_we, cpu_index, cpu_way, cpu_offset, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  fill_start, wb_start, line_index, line_way,
      output busy, done,
      input  mem_rdata, mem_rvalid, mem_wready,
      output mem_rready, mem_wdata, mem_wvalid, mem_wlast,
      output ram_index, ram_way, ram_offset, ram_din, ram_we, ram_en,
      input  ram_dout0, ram_dout1, ram_dout2, ram_dout3
   );

   modport master (
      output cpu_req, cpu_we, cpu_index, cpu_way, cpu_offset, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output fill_start, wb_start, line_index, line_way,
      input  busy, done,
      output mem_rdata, mem_rvalid, mem_wready,
      input  mem_rready, mem_wdata, mem_wvalid, mem_wlast,
      input  ram_index, ram_way, ram_offset, ram_din, ram_we, ram_en,
      output ram_dout0, ram_dout1, ram_dout2, ram_dout3
   );

endinterface

// File: rtl/dcache_data_ctrl_way_mux.sv
// 4:1 way selector over the four ddram read-data buses. Shared by the CPU
// load path and the writeback path.
module dcache_data_ctrl_way_mux #(
   parameter int DW = 32
) (
   input  logic [1:0]    i_sel,
   input  logic [DW-1:0] i_d0,
   input  logic [DW-1:0] i_d1,
   input  logic [DW-1:0] i_d2,
   input  logic [DW-1:0] i_d3,
   output logic [DW-1:0] o_q
);

   // Pick the read word of the selected way.
   always_comb begin
      o_q = i_d0;
      case (i_sel)
         2'd0:    o_q = i_d0;
         2'd1:    o_q = i_d1;
         2'd2:    o_q = i_d2;
         default: o_q = i_d3;
      endcase
   end

endmodule

// File: rtl/dcache_data_ctrl.sv
// Data RAM sequencer: arbitrates the single ddram port between CPU word
// accesses and line writeback / refill bursts.
module dcache_data_ctrl
   import dcache_data_ctrl_pkg::*;
#(
   parameter int DW = 32,
   parameter int IW = D_INDEX_WIDTH,
   parameter int WO = D_WO_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   dcache_data_ctrl_if.slave  bus
);

   localparam logic [WO-1:0] LAST_WORD = '1;

   ddc_state_e    r_state;
   ddc_state_e    w_state_next;
   logic [WO-1:0] r_cnt;
   logic [WO-1:0] w_cnt_next;
   logic          r_pend;
   logic          w_pend_next;
   logic [IW-1:0] r_index;
   logic [IW-1:0] w_index_next;
   logic [1:0]    r_way;
   logic [1:0]    w_way_next;
   logic [DW-1:0] r_rdata;
   logic          r_ack;
   logic          w_accept;
   logic [1:0]    w_mux_sel;
   logic [DW-1:0] w_mux_q;

   // During writeback the mux follows the latched way, otherwise the CPU way.
   assign w_mux_sel = (r_state == DDC_WB) ? r_way : bus.cpu_way;

   dcache_data_ctrl_way_mux #(.DW(DW)) u_way_mux (
      .i_sel (w_mux_sel),
      .i_d0  (bus.ram_dout0),
      .i_d1  (bus.ram_dout1),
      .i_d2  (bus.ram_dout2),
      .i_d3  (bus.ram_dout3),
      .o_q   (w_mux_q)
   );

   // Kept out of the FSM block so the RAM address never depends on read data.
   assign bus.mem_wdata = (r_state == DDC_WB) ? w_mux_q : '0;
   assign bus.cpu_rdata = r_rdata;
   assign bus.cpu_ack   = r_ack;
   assign bus.busy      = (r_state != DDC_IDLE);
   assign bus.done      = (r_state == DDC_DONE);

   // State, counter, latched line address and registered CPU response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= DDC_IDLE;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_index <= '0;
         r_way   <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pend  <= w_pend_next;
         r_index <= w_index_next;
         r_way   <= w_way_next;
         r_ack   <= w_accept;
         if (w_accept) begin
            r_rdata <= w_mux_q;
         end
      end
   end

   // Next-state logic and RAM / memory-bus port drive.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_pend_next    = r_pend;
      w_index_next   = r_index;
      w_way_next     = r_way;
      w_accept       = 1'b0;
      bus.ram_index  = '0;
      bus.ram_way    = '0;
      bus.ram_offset = '0;
      bus.ram_din    = '0;
      bus.ram_we     = 1'b0;
      bus.ram_en     = 1'b0;
      bus.mem_rready = 1'b0;
      bus.mem_wvalid = 1'b0;
      bus.mem_wlast  = 1'b0;

      case (r_state)
         DDC_IDLE: begin
            if (bus.wb_start) begin
               // A simultaneous fill is remembered and runs after the eviction.
               w_state_next = DDC_WB;
               w_pend_next  = bus.fill_start;
               w_index_next = bus.line_index;
               w_way_next   = bus.line_way;
               w_cnt_next   = '0;
            end else if (bus.fill_start) begin
               w_state_next = DDC_FILL;
               w_pend_next  = 1'b0;
               w_index_next = bus.line_index;
               w_way_next   = bus.line_way;
               w_cnt_next   = '0;
            end else if (bus.cpu_req && !r_ack) begin
               // No acceptance in the ack cycle: each request is served once.
               w_accept       = 1'b1;
               bus.ram_en     = 1'b1;
               bus.ram_we     = bus.cpu_we;
               bus.ram_index  = bus.cpu_index;
               bus.ram_way    = bus.cpu_way;
               bus.ram_offset = bus.cpu_offset;
               bus.ram_din    = bus.cpu_wdata;
            end
         end

         DDC_WB: begin
            bus.ram_en     = 1'b1;
            bus.ram_index  = r_index;
            bus.ram_way    = r_way;
            bus.ram_offset = r_cnt;
            bus.mem_wvalid = 1'b1;
            bus.mem_wlast  = (r_cnt == LAST_WORD);
            if (bus.mem_wready) begin
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == LAST_WORD) begin
                  w_state_next = r_pend ? DDC_FILL : DDC_DONE;
                  w_pend_next  = 1'b0;
               end
            end
         end

         DDC_FILL: begin
            bus.mem_rready = 1'b1;
            bus.ram_index  = r_index;
            bus.ram_way    = r_way;
            bus.ram_offset = r_cnt;
            bus.ram_din    = bus.mem_rdata;
            bus.ram_en     = bus.mem_rvalid;
            bus.ram_we     = bus.mem_rvalid;
            if (bus.mem_rvalid) begin
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == LAST_WORD) begin
                  w_state_next = DDC_DONE;
               end
            end
         end

         default: begin
            w_state_next = DDC_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Directed bench for dcache_data_ctrl with a behavioural 4-way ddram model.
module tb_dcache_data_ctrl;
   import dcache_data_ctrl_pkg::*;

   localparam int DW = 32;
   localparam int IW = 6;
   localparam int WO = 3;
   localparam int NW = D_LINE_WORDS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_seen = 0;

   always #5 clk = ~clk;

   dcache_data_ctrl_if #(.DW(DW), .IW(IW), .WO(WO)) bus ();

   dcache_data_ctrl #(.DW(DW), .IW(IW), .WO(WO)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ddram model: synchronous write, combinational read of all four ways.
   logic [DW-1:0] ram_q [4][1<<IW][NW];
   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we)
         ram_q[bus.ram_way][bus.ram_index][bus.ram_offset] <= bus.ram_din;
   end
   assign bus.ram_dout0 = ram_q[0][bus.ram_index][bus.ram_offset];
   assign bus.ram_dout1 = ram_q[1][bus.ram_index][bus.ram_offset];
   assign bus.ram_dout2 = ram_q[2][bus.ram_index][bus.ram_offset];
   assign bus.ram_dout3 = ram_q[3][bus.ram_index][bus.ram_offset];

   always @(posedge clk) begin
      if (bus.done) done_seen <= done_seen + 1;
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One CPU access; returns read data and cycles from request to ack.
   task automatic cpu_access(input logic we, input logic [IW-1:0] idx, input logic [1:0] way,
                             input logic [WO-1:0] off, input logic [DW-1:0] wd,
                             output logic [DW-1:0] rd, output int lat);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_index = idx;
      bus.cpu_way = way; bus.cpu_offset = off; bus.cpu_wdata = wd;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!bus.cpu_ack && lat < 50);
      rd = bus.cpu_rdata;
      $display("cpu %s idx=%0d way=%0d off=%0d wd=0x%08h rd=0x%08h lat=%0d",
               we ? "st" : "ld", idx, way, off, wd, rd, lat);
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      step();
   endtask

   task automatic start_line(input logic wb, input logic fill, input logic [IW-1:0] idx,
                             input logic [1:0] way);
      bus.wb_start = wb; bus.fill_start = fill; bus.line_index = idx; bus.line_way = way;
      step();
      bus.wb_start = 1'b0; bus.fill_start = 1'b0;
      check_vec("start_busy", bus.busy, 1);
   endtask

   // Supply a line; optional idle cycle before each valid word.
   task automatic feed_fill(input logic [DW-1:0] base, input logic gap);
      for (int i = 0; i < NW; i++) begin
         if (gap) begin
            bus.mem_rvalid = 1'b0;
            step();
         end
         bus.mem_rvalid = 1'b1; bus.mem_rdata = base + i;
         #1;
         check_vec("fill_rready", bus.mem_rready, 1);
         $display("fill word %0d = 0x%08h", i, base + i);
         step();
      end
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
   endtask

   // Drain a writeback under a ready pattern, checking order, stability and wlast.
   task automatic drain_wb(input logic [DW-1:0] base, input logic [15:0] pat);
      int k;
      int cyc;
      k = 0; cyc = 0;
      while (k < NW && cyc < 100) begin
         bus.mem_wready = pat[cyc % 16];
         #1;
         check_vec("wb_wvalid", bus.mem_wvalid, 1);
         check_vec("wb_wdata", bus.mem_wdata, base + k);
         check_vec("wb_wlast", bus.mem_wlast, (k == NW - 1) ? 1 : 0);
         $display("wb cyc %0d ready=%0b word %0d data=0x%08h last=%0b",
                  cyc, bus.mem_wready, k, bus.mem_wdata, bus.mem_wlast);
         if (bus.mem_wready) k++;
         step();
         cyc++;
      end
      bus.mem_wready = 1'b0;
      check_vec("wb_count", k, NW);
   endtask

   initial begin
      logic [DW-1:0] rd;
      int lat;
      int d0;
      int n;

      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_index = '0; bus.cpu_way = '0;
      bus.cpu_offset = '0; bus.cpu_wdata = '0; bus.fill_start = 0; bus.wb_start = 0;
      bus.line_index = '0; bus.line_way = '0; bus.mem_rdata = '0; bus.mem_rvalid = 0;
      bus.mem_wready = 0;

      // Reset state
      step(); step();
      check_vec("rst_busy", bus.busy, 0);
      check_vec("rst_done", bus.done, 0);
      check_vec("rst_ack", bus.cpu_ack, 0);
      check_vec("rst_rdata", bus.cpu_rdata, 0);
      check_vec("rst_ram_en", bus.ram_en, 0);
      check_vec("rst_wvalid", bus.mem_wvalid, 0);
      check_vec("rst_rready", bus.mem_rready, 0);
      rst_n = 1'b1;
      step();

      // Store then load
      cpu_access(1'b1, 6'd5, 2'd2, 3'd3, 32'hDEADBEEF, rd, lat);
      check_vec("st_lat", lat, 1);
      check_vec("st_ram", ram_q[2][5][3], 32'hDEADBEEF);
      check_vec("st_ack_drop", bus.cpu_ack, 0);
      cpu_access(1'b0, 6'd5, 2'd2, 3'd3, 32'h0, rd, lat);
      check_vec("ld_lat", lat, 1);
      check_vec("ld_data", rd, 32'hDEADBEEF);

      // Refill with gaps
      d0 = done_seen;
      start_line(1'b0, 1'b1, 6'd9, 2'd1);
      feed_fill(32'h100, 1'b1);
      check_vec("fill_done", bus.done, 1);
      step();
      check_vec("fill_done_drop", bus.done, 0);
      check_vec("fill_busy_drop", bus.busy, 0);
      check_vec("fill_done_cnt", done_seen - d0, 1);
      for (int i = 0; i < NW; i++) check_vec("fill_ram", ram_q[1][9][i], 32'h100 + i);

      // Writeback with backpressure
      for (int i = 0; i < NW; i++) cpu_access(1'b1, 6'd12, 2'd3, i[WO-1:0], 32'hA000 + i, rd, lat);
      d0 = done_seen;
      start_line(1'b1, 1'b0, 6'd12, 2'd3);
      drain_wb(32'hA000, 16'hA5C3);
      check_vec("wb_done", bus.done, 1);
      step();
      check_vec("wb_busy_drop", bus.busy, 0);
      check_vec("wb_done_cnt", done_seen - d0, 1);

      // Combined evict then refill
      for (int i = 0; i < NW; i++) cpu_access(1'b1, 6'd20, 2'd0, i[WO-1:0], 32'hB000 + i, rd, lat);
      d0 = done_seen;
      start_line(1'b1, 1'b1, 6'd20, 2'd0);
      drain_wb(32'hB000, 16'hFFFF);
      check_vec("comb_in_fill", bus.done, 0);
      feed_fill(32'hC000, 1'b0);
      check_vec("comb_done", bus.done, 1);
      step();
      check_vec("comb_done_cnt", done_seen - d0, 1);
      for (int i = 0; i < NW; i++) check_vec("comb_ram", ram_q[0][20][i], 32'hC000 + i);

      // CPU request colliding with a fill start
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_index = 6'd9; bus.cpu_way = 2'd1;
      bus.cpu_offset = 3'd5;
      bus.fill_start = 1; bus.line_index = 6'd9; bus.line_way = 2'd1;
      #1;
      check_vec("cont_ram_en", bus.ram_en, 0);
      step();
      bus.fill_start = 0;
      check_vec("cont_ack0", bus.cpu_ack, 0);
      for (int i = 0; i < NW; i++) begin
         bus.mem_rvalid = 1; bus.mem_rdata = 32'h200 + i;
         #1;
         check_vec("cont_ack_wait", bus.cpu_ack, 0);
         step();
      end
      bus.mem_rvalid = 0;
      check_vec("cont_done", bus.done, 1);
      check_vec("cont_ack_done", bus.cpu_ack, 0);
      n = 0;
      while (!bus.cpu_ack && n < 10) begin
         step();
         n++;
      end
      check_vec("cont_wait", n, 2);
      check_vec("cont_ack", bus.cpu_ack, 1);
      check_vec("cont_rdata", bus.cpu_rdata, 32'h205);
      $display("cont load rdata=0x%08h after %0d cycles", bus.cpu_rdata, n);
      bus.cpu_req = 0;
      step();

      // Reset in the middle of a refill
      cpu_access(1'b1, 6'd30, 2'd2, 3'd2, 32'h5555, rd, lat);
      d0 = done_seen;
      start_line(1'b0, 1'b1, 6'd30, 2'd2);
      for (int i = 0; i < 2; i++) begin
         bus.mem_rvalid = 1; bus.mem_rdata = 32'h300 + i;
         step();
      end
      bus.mem_rdata = 32'h302;
      rst_n = 1'b0;
      #1;
      check_vec("mrst_busy", bus.busy, 0);
      check_vec("mrst_rready", bus.mem_rready, 0);
      check_vec("mrst_ram_en", bus.ram_en, 0);
      check_vec("mrst_done", bus.done, 0);
      check_vec("mrst_rdata", bus.cpu_rdata, 0);
      step();
      bus.mem_rvalid = 0;
      rst_n = 1'b1;
      step(); step();
      check_vec("mrst_no_done", done_seen - d0, 0);
      check_vec("mrst_w0", ram_q[2][30][0], 32'h300);
      check_vec("mrst_w1", ram_q[2][30][1], 32'h301);
      check_vec("mrst_w2", ram_q[2][30][2], 32'h5555);
      cpu_access(1'b0, 6'd30, 2'd2, 3'd1, 32'h0, rd, lat);
      check_vec("mrst_ld", rd, 32'h301);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
